alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Decode/issue stage directly upstream of the ALU. Accepts RV32I register-register and register-immediate ALU instructions over a valid/ready handshake and decodes them into the ALU's 5-bit operation code. It reads operands from an internal 32x32 register file and drives a registered operand/opcode bundle into the ALU. It captures the ALU's combinational `result` back into the register file and a writeback port, resolving back-to-back RAW hazards by forwarding or stalling.

## Interface
- `XLEN`, 32, datapath width; only 32 is supported.
- `REGFILE_RESET`, 1, when 1 the register file clears to 0 on reset; when 0 it holds its contents through reset.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: `in_instr` is valid.
- `in_ready` out 1: stage accepts `in_instr` this cycle.
- `in_instr` in 32: RV32I instruction word.
- `operand_a` out 32: to ALU, registered.
- `operand_b` out 32: to ALU, registered.
- `alu_op` out 5: to ALU, registered.
- `ex_valid` out 1: the E register holds a live instruction.
- `alu_result` in 32: ALU `result`, combinational from `operand_a`, `operand_b` and `alu_op`.
- `wb_valid` out 1: one-cycle pulse when a register write has completed.
- `wb_rd` out 5: destination of the completed write.
- `wb_data` out 32: value written.
- `err_illegal` out 1: sticky flag, set on any illegal instruction and cleared only by reset.

## Operation
- **Decode.** Combinational on `in_instr`; only opcode 0110011 (R-type) and 0010011 (I-type) are legal.
- **funct3 to `alu_op`:**
  - 000: ADD 00000, or SUB 00001 when R-type and funct7=0100000.
  - 001: SLL 00110.
  - 010: SLT 00101.
  - 100: XOR 00100.
  - 101: SRL 00111 when funct7=0000000; SRA 01000 when funct7=0100000.
  - 110: OR 00011.
  - 111: AND 00010.
- **Illegal cases.** Any of the following is illegal:
  - funct3=011 (SLTU).
  - R-type funct7 not in {0000000, 0100000}.
  - R-type funct7=0100000 with funct3 not in {000, 101}.
  - Shift-immediate funct7 not in {0000000, 0100000}.
  - Any other opcode.
- **Illegal handling.** The instruction is still accepted:
  - `alu_op`=11111, `operand_a`=`operand_b`=0.
  - No register write.
  - `err_illegal` is set on the edge that accepts it.
- **Operand B.** For R-type, operand B is rs2. For I-type, it is sign-extended `instr[31:20]`; for shifts it is zero-extended shamt `instr[24:20]`.
- **E register.** Loads `operand_a`, `operand_b`, `alu_op`, rd and a write-enable on each edge with `in_valid && in_ready`. Write-enable = legal && rd≠0.
  - `ex_valid` is 1 for exactly the cycle after acceptance, and 0 if nothing was accepted.
- **Retire.** On the edge ending an `ex_valid` cycle with write-enable set:
  - `regfile[rd]` ← `alu_result`.
  - `wb_valid`=1, `wb_rd`=rd, `wb_data`=`alu_result` for the following cycle.
- **x0.** Always reads 0 and is never written.
- **Hazard.** A RAW hazard exists when `ex_valid`, write-enable is set, and the incoming rs1 or rs2 (rs2 for R-type only) equals E's rd. Behaviour depends on `ALU_ISSUE_FWD_EN` (see Configuration).
- **Backpressure.** The ALU never backpressures; the stage drains unconditionally.

## Timing
- **Reset values.** All of the following are 0: `in_ready`, `operand_a`, `operand_b`, `alu_op`, `ex_valid`, `wb_valid`, `wb_rd`, `wb_data`, `err_illegal`. `in_ready` rises to 1 in the first cycle after deassertion. Register file behaviour follows `REGFILE_RESET`.
- **Latency.** Accepted at edge N → ALU inputs valid cycle N+1 → regfile written and `wb_*` valid after edge N+1.
- **Throughput.** 1 instruction/cycle without hazards.
- **Forwarding.** Forwarded operands come from the same-cycle `alu_result`; the register file has no write-before-read bypass because the write lands on the same edge that captures E.
- **Reset mid-operation.** Asserting `rst_n` low immediately clears `ex_valid` and `wb_valid`. The in-flight instruction is discarded and never written.
- **Handshake.** `in_instr` is only sampled when `in_valid && in_ready`. When `in_ready`=0, the upstream source holds `in_valid` and `in_instr` stable.

## Configuration
- `ALU_ISSUE_FWD_EN` defined:
  - On a hazard, the matching operand is taken from `alu_result`.
  - `in_ready` stays 1; no bubble.
- `ALU_ISSUE_FWD_EN` undefined:
  - On a hazard, `in_ready`=0 for one cycle and the E register loads a bubble (`ex_valid`=0).
  - The instruction is accepted the next cycle and reads the just-written register file value.

## Test plan
- Reset, then `addi x1,x0,10` followed by `addi x2,x0,15` → `alu_op`=00000, `operand_b`=10 then 15; wb pulses (1,10) and (2,15).
- Back-to-back `addi x3,x0,5` then `sub x4,x3,x3`:
  - With FWD_EN: no stall, `operand_a`=`operand_b`=5, wb (4,0).
  - Without FWD_EN: exactly one `in_ready`=0 cycle, same final result.
- `srai x5,x1,3` with x1=0xFFFFFFF8 → `alu_op`=01000, `operand_b`=3, wb (5,0xFFFFFFFF); `slli` with funct7=0000001 → `err_illegal`=1, no wb.
- `add x0,x1,x2` → `ex_valid`=1, no `wb_valid`, and x0 still reads 0 on a later `add x6,x0,x0` (wb (6,0)).
- Opcode 0000011 (load) → `alu_op`=11111, operands 0, `err_illegal` sticky through 10 following legal instructions.
- Assert `rst_n` low while `ex_valid`=1 for `addi x7,x0,1` → no wb; after release, x7 reads 0 (`REGFILE_RESET`=1).

Source files
------------

// File: rtl/alu_issue_stage.sv
// Decode/issue stage feeding a combinational RV32I ALU, with a 32x32 register file and writeback.
// Define ALU_ISSUE_FWD_EN to forward alu_result on RAW hazards; otherwise they stall one cycle.
module alu_issue_stage #(
    parameter int XLEN          = 32,
    parameter bit REGFILE_RESET = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [31:0]     i_in_instr,
    output logic [XLEN-1:0] o_operand_a,
    output logic [XLEN-1:0] o_operand_b,
    output logic [4:0]      o_alu_op,
    output logic            o_ex_valid,
    input  logic [XLEN-1:0] i_alu_result,
    output logic            o_wb_valid,
    output logic [4:0]      o_wb_rd,
    output logic [XLEN-1:0] o_wb_data,
    output logic            o_err_illegal
);
    localparam logic [4:0] OP_ADD = 5'b00000, OP_SUB = 5'b00001, OP_AND = 5'b00010,
                           OP_OR  = 5'b00011, OP_XOR = 5'b00100, OP_SLT = 5'b00101,
                           OP_SLL = 5'b00110, OP_SRL = 5'b00111, OP_SRA = 5'b01000,
                           OP_ILL = 5'b11111;
    localparam logic [6:0] OPC_R = 7'b0110011, OPC_I = 7'b0010011;
    localparam logic [6:0] F7_Z  = 7'b0000000, F7_ALT = 7'b0100000;

    typedef struct packed {
        logic [4:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [4:0]      rd;
        logic            we;
    } ex_t;

    logic [XLEN-1:0] r_rf [0:31];
    ex_t             r_ex;
    logic            r_ex_valid, r_rdy, r_wb_valid, r_err;
    logic [4:0]      r_wb_rd;
    logic [XLEN-1:0] r_wb_data;

    logic [6:0]      w_opc, w_f7;
    logic [2:0]      w_f3;
    logic [4:0]      w_rs1, w_rs2, w_rd, w_op;
    logic            w_is_r, w_is_i, w_legal, w_shift, w_acc, w_stall, w_wr;
    logic            w_haz_a, w_haz_b;
    logic [XLEN-1:0] w_imm, w_rs1_val, w_rs2_val, w_src_a, w_src_b;
    ex_t             w_nxt;

    assign w_opc   = i_in_instr[6:0];
    assign w_rd    = i_in_instr[11:7];
    assign w_f3    = i_in_instr[14:12];
    assign w_rs1   = i_in_instr[19:15];
    assign w_rs2   = i_in_instr[24:20];
    assign w_f7    = i_in_instr[31:25];
    assign w_is_r  = (w_opc == OPC_R);
    assign w_is_i  = (w_opc == OPC_I);
    assign w_shift = (w_f3 == 3'b001) || (w_f3 == 3'b101);

    always_comb begin
        w_legal = 1'b0;
        w_op    = OP_ILL;
        if (w_is_r || w_is_i) begin
            w_legal = 1'b1;
            case (w_f3)
                3'b000: w_op = (w_is_r && w_f7 == F7_ALT) ? OP_SUB : OP_ADD;
                3'b001: w_op = OP_SLL;
                3'b010: w_op = OP_SLT;
                3'b011: w_legal = 1'b0;
                3'b100: w_op = OP_XOR;
                3'b101: w_op = (w_f7 == F7_ALT) ? OP_SRA : OP_SRL;
                3'b110: w_op = OP_OR;
                3'b111: w_op = OP_AND;
            endcase
            // For I-type, funct7 is only meaningful on shifts; elsewhere it is immediate bits.
            if ((w_is_r || w_shift) && w_f7 != F7_Z && w_f7 != F7_ALT)
                w_legal = 1'b0;
            if (w_is_r && w_f7 == F7_ALT && w_f3 != 3'b000 && w_f3 != 3'b101)
                w_legal = 1'b0;
            if (!w_legal)
                w_op = OP_ILL;
        end
    end

    assign w_imm     = w_shift ? {{(XLEN-5){1'b0}}, i_in_instr[24:20]}
                               : {{(XLEN-12){i_in_instr[31]}}, i_in_instr[31:20]};
    assign w_rs1_val = (w_rs1 == 5'd0) ? '0 : r_rf[w_rs1];
    assign w_rs2_val = (w_rs2 == 5'd0) ? '0 : r_rf[w_rs2];

    // r_ex.we already excludes rd=x0, so x0 never creates a hazard.
    assign w_haz_a = r_ex_valid && r_ex.we && w_legal && (w_rs1 == r_ex.rd);
    assign w_haz_b = r_ex_valid && r_ex.we && w_legal && w_is_r && (w_rs2 == r_ex.rd);

`ifdef ALU_ISSUE_FWD_EN
    assign w_src_a = w_haz_a ? i_alu_result : w_rs1_val;
    assign w_src_b = w_haz_b ? i_alu_result : w_rs2_val;
    assign w_stall = 1'b0;
`else
    // Register file write lands on the same edge E loads, so hold off one cycle instead.
    assign w_src_a = w_rs1_val;
    assign w_src_b = w_rs2_val;
    assign w_stall = w_haz_a || w_haz_b;
`endif

    assign o_in_ready = r_rdy && !w_stall;
    assign w_acc      = i_in_valid && o_in_ready;
    assign w_wr       = r_ex_valid && r_ex.we;

    always_comb begin
        w_nxt    = '0;
        w_nxt.op = w_op;
        w_nxt.rd = w_rd;
        w_nxt.we = w_legal && (w_rd != 5'd0);
        if (w_legal) begin
            w_nxt.a = w_src_a;
            w_nxt.b = w_is_r ? w_src_b : w_imm;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdy      <= 1'b0;
            r_ex_valid <= 1'b0;
            r_ex       <= '0;
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_rdy      <= 1'b1;
            r_ex_valid <= w_acc;
            if (w_acc)
                r_ex <= w_nxt;
            r_wb_valid <= w_wr;
            if (w_wr) begin
                r_wb_rd   <= r_ex.rd;
                r_wb_data <= i_alu_result;
            end
            if (w_acc && !w_legal)
                r_err <= 1'b1;
        end
    end

    if (REGFILE_RESET) begin : g_rf_rst
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                for (int i = 0; i < 32; i++)
                    r_rf[i] <= '0;
            end else if (w_wr) begin
                r_rf[r_ex.rd] <= i_alu_result;
            end
        end
    end else begin : g_rf_hold
        always_ff @(posedge i_clk) begin
            if (w_wr)
                r_rf[r_ex.rd] <= i_alu_result;
        end
    end

    assign o_operand_a   = r_ex.a;
    assign o_operand_b   = r_ex.b;
    assign o_alu_op      = r_ex.op;
    assign o_ex_valid    = r_ex_valid;
    assign o_wb_valid    = r_wb_valid;
    assign o_wb_rd       = r_wb_rd;
    assign o_wb_data     = r_wb_data;
    assign o_err_illegal = r_err;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: architectural reference model, per-cycle compare, literal pins.
module tb_alu_issue_stage;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic        in_ready, ex_valid, wb_valid, err_illegal;
    logic [31:0] operand_a, operand_b, alu_result, wb_data;
    logic [4:0]  alu_op, wb_rd;

    int checks = 0, errors = 0, stall_cnt = 0;

    alu_issue_stage #(.XLEN(32), .REGFILE_RESET(1'b1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_in_instr(in_instr), .o_operand_a(operand_a), .o_operand_b(operand_b),
        .o_alu_op(alu_op), .o_ex_valid(ex_valid), .i_alu_result(alu_result),
        .o_wb_valid(wb_valid), .o_wb_rd(wb_rd), .o_wb_data(wb_data),
        .o_err_illegal(err_illegal));

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            5'd0: return a + b;
            5'd1: return a - b;
            5'd2: return a & b;
            5'd3: return a | b;
            5'd4: return a ^ b;
            5'd5: return {31'b0, $signed(a) < $signed(b)};
            5'd6: return a << b[4:0];
            5'd7: return a >> b[4:0];
            5'd8: return $signed(a) >>> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    assign alu_result = alu_f(alu_op, operand_a, operand_b);

    function automatic void mdec(input logic [31:0] ins, output logic legal, output logic [4:0] op,
                                 output logic is_r, output logic [31:0] imm);
        logic [6:0] opc;
        logic [6:0] f7;
        logic [2:0] f3;
        logic       is_i, shf;
        opc = ins[6:0]; f7 = ins[31:25]; f3 = ins[14:12];
        is_r = (opc == 7'h33); is_i = (opc == 7'h13);
        shf = (f3 == 3'd1) || (f3 == 3'd5);
        legal = is_r || is_i;
        if (f3 == 3'd3) legal = 1'b0;
        if (is_r && f7 != 7'h00 && f7 != 7'h20) legal = 1'b0;
        if (is_r && f7 == 7'h20 && f3 != 3'd0 && f3 != 3'd5) legal = 1'b0;
        if (is_i && shf && f7 != 7'h00 && f7 != 7'h20) legal = 1'b0;
        op = 5'h1F;
        if (legal)
            case (f3)
                3'd0: op = (is_r && f7 == 7'h20) ? 5'd1 : 5'd0;
                3'd1: op = 5'd6;
                3'd2: op = 5'd5;
                3'd4: op = 5'd4;
                3'd5: op = (f7 == 7'h20) ? 5'd8 : 5'd7;
                3'd6: op = 5'd3;
                3'd7: op = 5'd2;
                default: op = 5'h1F;
            endcase
        imm = shf ? {27'b0, ins[24:20]} : {{20{ins[31]}}, ins[31:20]};
    endfunction

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
        end
    endtask

    // Architectural model: registers update in program order at acceptance.
    logic [31:0] mrf [0:31];
    logic        m_rdy, m_err, m_ex_v, m_ex_we, m_wb_v;
    logic [4:0]  m_ex_op, m_ex_rd, m_wb_rd;
    logic [31:0] m_ex_a, m_ex_b, m_wb_d;
    logic        acc = 1'b0, p_legal, p_we;
    logic [4:0]  p_op, p_rd;
    logic [31:0] p_a, p_b, p_res;
    logic [4:0]  q_ex_op [$];
    logic [31:0] q_ex_a [$], q_ex_b [$], q_wb_d [$];
    logic [4:0]  q_wb_rd [$];

    function automatic logic [31:0] rf_rd(input logic [4:0] r);
        return (r == 5'd0) ? 32'd0 : mrf[r];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rdy <= 1'b0; m_err <= 1'b0; m_ex_v <= 1'b0; m_ex_we <= 1'b0; m_wb_v <= 1'b0;
            m_ex_op <= '0; m_ex_rd <= '0; m_ex_a <= '0; m_ex_b <= '0; m_wb_rd <= '0; m_wb_d <= '0;
            for (int i = 0; i < 32; i++) mrf[i] <= '0;
        end else begin
            m_rdy  <= 1'b1;
            m_wb_v <= m_ex_v && m_ex_we;
            if (m_ex_v && m_ex_we) begin
                m_wb_rd <= m_ex_rd;
                m_wb_d  <= alu_f(m_ex_op, m_ex_a, m_ex_b);
            end
            m_ex_v <= acc;
            if (acc) begin
                m_ex_op <= p_op; m_ex_a <= p_a; m_ex_b <= p_b; m_ex_rd <= p_rd; m_ex_we <= p_we;
                if (p_we) mrf[p_rd] <= p_res;
                if (!p_legal) m_err <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        logic        l, r, haz, exp_rdy;
        logic [4:0]  op, rs1, rs2;
        logic [31:0] imm;
        if (!rst_n) begin
            acc = 1'b0;
            chk("rst_in_ready", in_ready, 0);
            chk("rst_operand_a", operand_a, 0);
            chk("rst_operand_b", operand_b, 0);
            chk("rst_alu_op", alu_op, 0);
            chk("rst_ex_valid", ex_valid, 0);
            chk("rst_wb_valid", wb_valid, 0);
            chk("rst_wb_rd", wb_rd, 0);
            chk("rst_wb_data", wb_data, 0);
            chk("rst_err", err_illegal, 0);
        end else begin
            mdec(in_instr, l, op, r, imm);
            rs1 = in_instr[19:15];
            rs2 = in_instr[24:20];
            haz = m_ex_v && m_ex_we && l && (rs1 == m_ex_rd || (r && rs2 == m_ex_rd));
`ifdef ALU_ISSUE_FWD_EN
            exp_rdy = m_rdy;
`else
            exp_rdy = m_rdy && !haz;
`endif
            if (in_valid) begin
                chk("in_ready", in_ready, exp_rdy);
                if (!in_ready) stall_cnt++;
            end
            chk("ex_valid", ex_valid, m_ex_v);
            if (m_ex_v) begin
                chk("alu_op", alu_op, m_ex_op);
                chk("operand_a", operand_a, m_ex_a);
                chk("operand_b", operand_b, m_ex_b);
            end
            chk("wb_valid", wb_valid, m_wb_v);
            if (m_wb_v) begin
                chk("wb_rd", wb_rd, m_wb_rd);
                chk("wb_data", wb_data, m_wb_d);
            end
            chk("err_illegal", err_illegal, m_err);
            if (ex_valid) begin
                q_ex_op.push_back(alu_op); q_ex_a.push_back(operand_a); q_ex_b.push_back(operand_b);
            end
            if (wb_valid) begin
                q_wb_rd.push_back(wb_rd); q_wb_d.push_back(wb_data);
            end
            acc = in_valid && exp_rdy;
            if (acc) begin
                p_legal = l; p_op = op; p_rd = in_instr[11:7];
                p_we  = l && (p_rd != 5'd0);
                p_a   = l ? rf_rd(rs1) : 32'd0;
                p_b   = !l ? 32'd0 : (r ? rf_rd(rs2) : imm);
                p_res = alu_f(op, p_a, p_b);
            end
        end
    end

    task automatic send(input logic [31:0] ins);
        int n = 0;
        in_valid = 1'b1;
        in_instr = ins;
        forever begin
            @(posedge clk);
            if (acc) break;
            n++;
            if (n >= 20) begin
                checks++; errors++;
                $display("FAIL accept_timeout instr=%h not accepted within 20 cycles", ins);
                break;
            end
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_ex(input string name, input int idx, input logic [4:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        if (idx >= q_ex_op.size()) begin
            chk({name, "_present"}, 0, 1);
        end else begin
            chk({name, "_op"}, q_ex_op[idx], op);
            chk({name, "_a"}, q_ex_a[idx], a);
            chk({name, "_b"}, q_ex_b[idx], b);
        end
    endtask

    task automatic chk_wb(input string name, input int idx, input logic [4:0] rd, input logic [31:0] d);
        if (idx >= q_wb_rd.size()) begin
            chk({name, "_present"}, 0, 1);
        end else begin
            chk({name, "_rd"}, q_wb_rd[idx], rd);
            chk({name, "_data"}, q_wb_d[idx], d);
        end
    endtask

    initial begin
        int exb, wbb, stb;
        logic [31:0] legal_seq [10];
        legal_seq = '{rtype(7'h00, 2, 1, 3'd6, 10), rtype(7'h00, 2, 1, 3'd7, 11),
                      rtype(7'h00, 2, 1, 3'd4, 12), rtype(7'h00, 2, 1, 3'd2, 13),
                      rtype(7'h00, 2, 1, 3'd5, 14), rtype(7'h20, 2, 1, 3'd5, 15),
                      rtype(7'h00, 2, 1, 3'd1, 16), itype(12'h0F0, 1, 3'd6, 17),
                      itype(12'h800, 1, 3'd2, 18), itype(12'hFFF, 13, 3'd4, 19)};
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_reset", in_ready, 1);

        // addi x1,x0,10 ; addi x2,x0,15
        exb = q_ex_op.size(); wbb = q_wb_rd.size();
        send(itype(12'd10, 0, 3'd0, 1));
        send(itype(12'd15, 0, 3'd0, 2));
        idle(3);
        chk_ex("addi10", exb, 5'd0, 32'd0, 32'd10);
        chk_ex("addi15", exb + 1, 5'd0, 32'd0, 32'd15);
        chk_wb("wb_x1", wbb, 5'd1, 32'd10);
        chk_wb("wb_x2", wbb + 1, 5'd2, 32'd15);

        // addi x3,x0,5 ; sub x4,x3,x3 back to back
        exb = q_ex_op.size(); wbb = q_wb_rd.size(); stb = stall_cnt;
        send(itype(12'd5, 0, 3'd0, 3));
        send(rtype(7'h20, 3, 3, 3'd0, 4));
        idle(3);
`ifdef ALU_ISSUE_FWD_EN
        chk("raw_stall_cycles", stall_cnt - stb, 0);
`else
        chk("raw_stall_cycles", stall_cnt - stb, 1);
`endif
        chk_ex("sub_raw", exb + 1, 5'd1, 32'd5, 32'd5);
        chk_wb("wb_x4", wbb + 1, 5'd4, 32'd0);

        // addi x1,x0,-8 ; srai x5,x1,3 ; slli with funct7=0000001 (illegal)
        exb = q_ex_op.size(); wbb = q_wb_rd.size();
        send(itype(12'hFF8, 0, 3'd0, 1));
        send(itype({7'h20, 5'd3}, 1, 3'd5, 5));
        send(itype({7'h01, 5'd1}, 1, 3'd1, 9));
        idle(3);
        chk_ex("srai", exb + 1, 5'd8, 32'hFFFF_FFF8, 32'd3);
        chk_wb("wb_x5", wbb + 1, 5'd5, 32'hFFFF_FFFF);
        chk_ex("slli_bad", exb + 2, 5'h1F, 32'd0, 32'd0);
        chk("wb_count_srai", q_wb_rd.size() - wbb, 2);
        chk("err_after_slli", err_illegal, 1);

        // add x0,x1,x2 ; add x6,x0,x0
        exb = q_ex_op.size(); wbb = q_wb_rd.size();
        send(rtype(7'h00, 2, 1, 3'd0, 0));
        send(rtype(7'h00, 0, 0, 3'd0, 6));
        idle(3);
        chk("ex_count_x0", q_ex_op.size() - exb, 2);
        chk("wb_count_x0", q_wb_rd.size() - wbb, 1);
        chk_wb("wb_x6", wbb, 5'd6, 32'd0);

        // load opcode then ten legal instructions
        exb = q_ex_op.size(); wbb = q_wb_rd.size();
        send({12'd4, 5'd1, 3'b010, 5'd3, 7'b0000011});
        foreach (legal_seq[i]) send(legal_seq[i]);
        idle(3);
        chk_ex("load_illegal", exb, 5'h1F, 32'd0, 32'd0);
        chk_wb("wb_or_x10", wbb, 5'd10, 32'hFFFF_FFFF);
        chk_wb("wb_slt_x13", wbb + 3, 5'd13, 32'd1);
        chk("wb_count_seq", q_wb_rd.size() - wbb, 10);
        chk("err_sticky", err_illegal, 1);

        // reset while addi x7,x0,1 sits in E
        send(itype(12'd1, 0, 3'd0, 7));
        chk("ex_valid_before_rst", ex_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_clears_ex_valid", ex_valid, 0);
        chk("rst_clears_wb_valid", wb_valid, 0);
        @(negedge clk); @(negedge clk);
        #2 rst_n = 1'b1;
        wbb = q_wb_rd.size();
        send(rtype(7'h00, 0, 7, 3'd0, 8));
        idle(3);
        chk_wb("wb_x8_after_rst", wbb, 5'd8, 32'd0);
        chk("wb_count_after_rst", q_wb_rd.size() - wbb, 1);
        chk("err_cleared_by_rst", err_illegal, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete by %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
